// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Consumed by btn_conditioner; the long-press feature is gated by BTN_COND_LONG_PRESS_EN.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int BTN_TICK_CYCLES_DEFAULT    = 2000;
  localparam int BTN_DEBOUNCE_TICKS_DEFAULT = 10;
  localparam int BTN_LONG_TICKS_DEFAULT     = 500;

  // Counter width that never collapses to zero bits for degenerate parameters.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser with synchronous active-high reset.
// Generic width so the same block serves every asynchronous pad input.
module btn_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make both stages sample pre-edge values, giving a real 2-flop chain.
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: synchronise, debounce on a slow tick, emit level plus press/release/long-press pulses.
// Optional feature macro: BTN_COND_LONG_PRESS_EN (hold counter and long_press_o); undefined ties long_press_o to 0.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int TICK_CYCLES    = BTN_TICK_CYCLES_DEFAULT,
  parameter int DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS_DEFAULT,
  parameter int LONG_TICKS     = BTN_LONG_TICKS_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int TickW = cnt_width(TICK_CYCLES);
  localparam int DebW  = cnt_width(DEBOUNCE_TICKS + 1);

  logic s;

  btn_sync #(
    .WIDTH (1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (btn_raw_i),
    .q_o   (s)
  );

  // Free-running tick generator.
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  always_comb begin
    tick       = (tick_cnt_q == TickW'(TICK_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  btn_state_e       state_q, state_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [DebW-1:0]  deb_inc;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    deb_d   = deb_q;
    deb_inc = deb_q + DebW'(1);
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (tick) begin
          deb_d = deb_inc;
          if (deb_inc == DebW'(DEBOUNCE_TICKS)) state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          deb_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (tick) begin
          deb_d = deb_inc;
          if (deb_inc == DebW'(DEBOUNCE_TICKS)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    btn_d     = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      deb_q      <= '0;
      btn_q      <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      deb_q      <= deb_d;
      btn_q      <= btn_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_COND_LONG_PRESS_EN
  localparam int HoldW = cnt_width(LONG_TICKS + 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;
  logic             held;

  // Counting is suppressed on the tick that lands in IDLE, so long_press never shares a cycle with release.
  always_comb begin
    held   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    hold_d = hold_q;
    if (state_d == IDLE) begin
      hold_d = '0;
    end else if (tick && held && (hold_q != HoldW'(LONG_TICKS))) begin
      hold_d = hold_q + HoldW'(1);
    end
    long_d = (hold_d == HoldW'(LONG_TICKS)) && (hold_q != HoldW'(LONG_TICKS));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press_o = long_q;
`else
  logic long_ticks_unused;
  assign long_ticks_unused = (LONG_TICKS != 0);
  assign long_press_o      = 1'b0;
`endif

endmodule
